// File: rtl/commit_unit_multi_pkg.sv
// LC-3b shared types: opcodes, commit FSM states and CC helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } commit_state_t;

  // Opcodes whose result writes a register and sets the condition codes.
  function automatic logic is_alu_class(lc3b_opcode op);
    return (op == op_add) || (op == op_and) || (op == op_not) ||
           (op == op_shf) || (op == op_lea) || (op == op_ldr);
  endfunction

  // Opcodes that must go through the data memory handshake.
  function automatic logic is_store_class(lc3b_opcode op);
    return (op == op_str) || (op == op_stb);
  endfunction

  // Condition codes {n,z,p} produced by a written value.
  function automatic lc3b_nzp gencc(lc3b_word v);
    if (v[15])            return 3'b100;
    else if (v == 16'h0)  return 3'b010;
    else                  return 3'b001;
  endfunction

  // Branch condition: any selected flag set.
  function automatic logic cccomp(lc3b_nzp cc, lc3b_nzp nzp);
    return |(cc & nzp);
  endfunction

endpackage

// File: rtl/commit_unit_multi_slot_decode.sv
// One head slot: classifies the entry, extends the retirement prefix,
// propagates the CC chain and resolves branch direction.
module commit_slot_decode
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  alive_i,
  input  logic                  valid_i,
  input  logic [3:0]            opcode_i,
  input  logic [2:0]            nzp_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  predict_i,
  input  logic [2:0]            cc_i,
  output logic                  retire_o,
  output logic                  write_o,
  output logic                  mispredict_o,
  output logic [2:0]            cc_o
);

  lc3b_opcode op;
  logic       alu;
  logic       jsr;
  logic       br;
  logic       store;
  logic       taken;

  assign op    = lc3b_opcode'(opcode_i);
  assign alu   = is_alu_class(op);
  assign jsr   = (op == op_jsr);
  assign br    = (op == op_br);
  assign store = is_store_class(op);

  // Stores never retire through the prefix; slot 0 stores use the FSM path.
  assign retire_o     = alive_i && valid_i && !store;
  assign taken        = cccomp(cc_i, nzp_i);
  assign mispredict_o = retire_o && br && (taken != predict_i);
  assign write_o      = alu || jsr;
  assign cc_o         = (retire_o && alu) ? gencc(lc3b_word'(value_i)) : cc_i;

endmodule

// File: rtl/commit_unit_multi.sv
// In-order multi-slot retirement: prefix retire, CC chain, branch
// redirect, store handshake and performance counters.
module commit_unit_multi
  import lc3b_types::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COMMIT_WIDTH-1:0]             head_valid,
  input  logic [COMMIT_WIDTH*4-1:0]           head_opcode,
  input  logic [COMMIT_WIDTH*3-1:0]           head_dest,
  input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]  head_value,
  input  logic [COMMIT_WIDTH-1:0]             head_predict,
  input  logic [COMMIT_WIDTH*TAG_WIDTH-1:0]   head_rob_addr,
  input  logic [COMMIT_WIDTH*TAG_WIDTH-1:0]   rat_tag,
  input  logic                                dmem_resp,
  output logic [COMMIT_WIDTH*3-1:0]           rf_dest,
  output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]  rf_value,
  output logic [COMMIT_WIDTH-1:0]             rf_ld_value,
  output logic [COMMIT_WIDTH-1:0]             rf_ld_busy,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]   retire_count,
  output logic                                flush,
  output logic                                pcmux_sel,
  output logic [15:0]                         new_pc,
  output logic                                dmem_write,
  output logic                                ldstr_re,
  output logic [CNT_WIDTH-1:0]                perf_retired,
  output logic [CNT_WIDTH-1:0]                perf_mispredict
);

  localparam int W   = COMMIT_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int TW  = TAG_WIDTH;
  localparam int RCW = $clog2(COMMIT_WIDTH + 1);

  commit_state_t  state_q, state_d;
  logic [2:0]     cc_q, cc_d;
  logic           flush_q, flush_d;
  logic [15:0]    pc_q, pc_d;
  logic [CNT_WIDTH-1:0] perf_ret_q, perf_mis_q;

  logic           slot0_store;
  logic           normal;
  logic           store_retire;
  logic [W-1:0]   retire_v, write_v, mis_v;

  // Prefix retirement is only open when no flush, no pending store and
  // slot 0 is not itself a store.
  assign slot0_store = head_valid[0] && is_store_class(lc3b_opcode'(head_opcode[3:0]));
  assign normal      = !rst && !flush_q && (state_q == IDLE) && !slot0_store;

  for (genvar g = 0; g < W; g++) begin : g_slot
    logic       alive, ret, wr, mis;
    logic [2:0] cc_in, cc_out;
    if (g == 0) begin : g_head
      assign alive = normal;
      assign cc_in = cc_q;
    end else begin : g_tail
      assign alive = g_slot[g-1].ret && !g_slot[g-1].mis;
      assign cc_in = g_slot[g-1].cc_out;
    end
    commit_slot_decode #(.DATA_WIDTH(DW)) u_dec (
      .alive_i      (alive),
      .valid_i      (head_valid[g]),
      .opcode_i     (head_opcode[g*4 +: 4]),
      .nzp_i        (head_dest[g*3 +: 3]),
      .value_i      (head_value[g*DW +: DW]),
      .predict_i    (head_predict[g]),
      .cc_i         (cc_in),
      .retire_o     (ret),
      .write_o      (wr),
      .mispredict_o (mis),
      .cc_o         (cc_out)
    );
    assign retire_v[g] = ret;
    assign write_v[g]  = wr;
    assign mis_v[g]    = mis;
  end

  assign cc_d    = g_slot[W-1].cc_out;
  assign flush_d = |mis_v;

  // Store handshake: request in the cycle slot 0 shows a store, hold until resp.
  always_comb begin
    state_d      = state_q;
    dmem_write   = 1'b0;
    ldstr_re     = 1'b0;
    store_retire = 1'b0;
    if (rst || flush_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (slot0_store) begin
            state_d    = WAIT;
            dmem_write = 1'b1;
          end
        end
        WAIT: begin
          dmem_write = 1'b1;
          if (dmem_resp) begin
            store_retire = 1'b1;
            ldstr_re     = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Regfile ports: a younger same-cycle writer to the same dest wins.
  always_comb begin
    rf_ld_value = '0;
    rf_ld_busy  = '0;
    rf_dest     = '0;
    rf_value    = '0;
    for (int i = 0; i < W; i++) begin
      if (retire_v[i] && write_v[i]) begin
        rf_ld_value[i] = 1'b1;
        for (int j = i + 1; j < W; j++) begin
          if (retire_v[j] && write_v[j] && (head_dest[j*3 +: 3] == head_dest[i*3 +: 3]))
            rf_ld_value[i] = 1'b0;
        end
      end
      rf_ld_busy[i] = rf_ld_value[i] && (rat_tag[i*TW +: TW] == head_rob_addr[i*TW +: TW]);
      if (rf_ld_value[i]) begin
        rf_dest[i*3 +: 3]    = head_dest[i*3 +: 3];
        rf_value[i*DW +: DW] = head_value[i*DW +: DW];
      end
    end
  end

  // Redirect target of the (at most one) mispredicting slot.
  always_comb begin
    pc_d = '0;
    for (int i = 0; i < W; i++) begin
      if (mis_v[i]) pc_d = 16'(head_value[i*DW +: DW]);
    end
  end

  // Entries popped this cycle: the prefix length, or the completing store.
  always_comb begin
    retire_count = '0;
    for (int i = 0; i < W; i++) retire_count = retire_count + RCW'(retire_v[i]);
    if (store_retire) retire_count = RCW'(1);
  end

  // Architectural and performance state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cc_q       <= 3'b010;
      flush_q    <= 1'b0;
      pc_q       <= '0;
      perf_ret_q <= '0;
      perf_mis_q <= '0;
    end else begin
      state_q    <= state_d;
      cc_q       <= cc_d;
      flush_q    <= flush_d;
      pc_q       <= pc_d;
      perf_ret_q <= perf_ret_q + CNT_WIDTH'(retire_count);
      perf_mis_q <= perf_mis_q + CNT_WIDTH'(flush_d);
    end
  end

  assign flush           = flush_q;
  assign pcmux_sel       = flush_q;
  assign new_pc          = pc_q;
  assign perf_retired    = perf_ret_q;
  assign perf_mispredict = perf_mis_q;

endmodule

// File: tb/tb_commit_unit_multi.sv
// Bench for commit_unit_multi: directed scenarios then random traffic,
// all compared against a rule-level reference model.
module tb_commit_unit_multi;

  localparam int W  = 2;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    head_valid;
  logic [W*4-1:0]  head_opcode;
  logic [W*3-1:0]  head_dest;
  logic [W*DW-1:0] head_value;
  logic [W-1:0]    head_predict;
  logic [W*TW-1:0] head_rob_addr;
  logic [W*TW-1:0] rat_tag;
  logic            dmem_resp;
  logic [W*3-1:0]  rf_dest;
  logic [W*DW-1:0] rf_value;
  logic [W-1:0]    rf_ld_value;
  logic [W-1:0]    rf_ld_busy;
  logic [1:0]      retire_count;
  logic            flush, pcmux_sel, dmem_write, ldstr_re;
  logic [15:0]     new_pc;
  logic [CW-1:0]   perf_retired, perf_mispredict;

  always #5 clk = ~clk;

  commit_unit_multi #(.COMMIT_WIDTH(W), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .head_valid(head_valid), .head_opcode(head_opcode),
    .head_dest(head_dest), .head_value(head_value), .head_predict(head_predict),
    .head_rob_addr(head_rob_addr), .rat_tag(rat_tag), .dmem_resp(dmem_resp),
    .rf_dest(rf_dest), .rf_value(rf_value), .rf_ld_value(rf_ld_value),
    .rf_ld_busy(rf_ld_busy), .retire_count(retire_count), .flush(flush),
    .pcmux_sel(pcmux_sel), .new_pc(new_pc), .dmem_write(dmem_write),
    .ldstr_re(ldstr_re), .perf_retired(perf_retired), .perf_mispredict(perf_mispredict)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [2:0]    m_cc;
  logic          m_wait, m_flush;
  logic [15:0]   m_pc;
  logic [CW-1:0] m_ret, m_mis;

  // 0 other, 1 alu, 2 jsr, 3 br, 4 store
  function automatic int op_class(logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd6, 4'd9, 4'd13, 4'd14: return 1;
      4'd4:                                 return 2;
      4'd0:                                 return 3;
      4'd3, 4'd7:                           return 4;
      default:                              return 0;
    endcase
  endfunction

  function automatic logic [2:0] cc_of(logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(int i, logic v, logic [3:0] op, logic [2:0] d, logic [15:0] val,
                          logic pr, logic match);
    logic [2:0] rob;
    rob = 3'($urandom_range(0, 7));
    head_valid[i]          = v;
    head_opcode[i*4 +: 4]  = op;
    head_dest[i*3 +: 3]    = d;
    head_value[i*DW +: DW] = val;
    head_predict[i]        = pr;
    head_rob_addr[i*3 +: 3] = rob;
    rat_tag[i*3 +: 3]       = match ? rob : (rob ^ 3'b001);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < W; i++) set_slot(i, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 1'b1);
  endtask

  // Evaluate one cycle: model expectations, compare at negedge, advance model.
  task automatic step();
    int n;
    logic mis, taken, e_dw, e_re, n_wait;
    logic [15:0] tgt, v;
    logic [2:0] cc;
    logic [W-1:0] e_ld, e_busy;
    logic [W*3-1:0] e_dest;
    logic [W*DW-1:0] e_val;
    @(negedge clk);
    if (rst) begin
      m_cc = 3'b010; m_wait = 1'b0; m_flush = 1'b0; m_pc = '0; m_ret = '0; m_mis = '0;
    end
    n = 0; mis = 1'b0; tgt = '0; cc = m_cc; e_dw = 1'b0; e_re = 1'b0; n_wait = m_wait;
    e_ld = '0; e_busy = '0; e_dest = '0; e_val = '0;
    if (rst || m_flush) begin
      n_wait = 1'b0;
    end else if (m_wait) begin
      e_dw = 1'b1;
      if (dmem_resp) begin n = 1; e_re = 1'b1; n_wait = 1'b0; end
    end else if (head_valid[0] && op_class(head_opcode[3:0]) == 4) begin
      e_dw = 1'b1; n_wait = 1'b1;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!head_valid[i] || op_class(head_opcode[i*4 +: 4]) == 4) break;
        n++;
        v = head_value[i*DW +: DW];
        if (op_class(head_opcode[i*4 +: 4]) == 1) cc = cc_of(v);
        if (op_class(head_opcode[i*4 +: 4]) == 3) begin
          taken = (cc & head_dest[i*3 +: 3]) != 3'b000;
          if (taken != head_predict[i]) begin mis = 1'b1; tgt = v; break; end
        end
      end
      for (int i = 0; i < n; i++) begin
        if (op_class(head_opcode[i*4 +: 4]) inside {1, 2}) begin
          e_ld[i] = 1'b1;
          for (int j = i + 1; j < n; j++)
            if (op_class(head_opcode[j*4 +: 4]) inside {1, 2} && head_dest[j*3 +: 3] == head_dest[i*3 +: 3])
              e_ld[i] = 1'b0;
          if (e_ld[i]) begin
            e_busy[i] = rat_tag[i*3 +: 3] == head_rob_addr[i*3 +: 3];
            e_dest[i*3 +: 3] = head_dest[i*3 +: 3];
            e_val[i*DW +: DW] = head_value[i*DW +: DW];
          end
        end
      end
    end
    chk("retire_count", 64'(retire_count), 64'(n));
    chk("rf_ld_value", 64'(rf_ld_value), 64'(e_ld));
    chk("rf_ld_busy", 64'(rf_ld_busy), 64'(e_busy));
    chk("rf_dest", 64'(rf_dest), 64'(e_dest));
    chk("rf_value", 64'(rf_value), 64'(e_val));
    chk("dmem_write", 64'(dmem_write), 64'(e_dw));
    chk("ldstr_re", 64'(ldstr_re), 64'(e_re));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("pcmux_sel", 64'(pcmux_sel), 64'(m_flush));
    chk("new_pc", 64'(new_pc), 64'(m_pc));
    chk("perf_retired", 64'(perf_retired), 64'(m_ret));
    chk("perf_mispredict", 64'(perf_mispredict), 64'(m_mis));
    if (!rst) begin
      m_cc = cc; m_wait = n_wait; m_flush = mis; m_pc = mis ? tgt : 16'd0;
      m_ret = m_ret + CW'(n); m_mis = m_mis + CW'(mis);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ops [12];
    ops = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd13, 4'd14, 4'd2, 4'd15};
    rst = 1'b1; dmem_resp = 1'b0;
    clear_slots();
    set_slot(0, 1'b1, 4'd1, 3'd1, 16'h0005, 1'b0, 1'b1);
    #1;
    step();                                            // outputs quiet in reset
    rst = 1'b0;
    clear_slots();
    step();

    set_slot(0, 1'b1, 4'd1, 3'd1, 16'h0005, 1'b0, 1'b1);   // add R1
    set_slot(1, 1'b1, 4'd1, 3'd2, 16'hFFFE, 1'b0, 1'b1);   // add R2, CC -> n
    step();
    set_slot(0, 1'b1, 4'd0, 3'b100, 16'h1234, 1'b1, 1'b1); // brn, correctly taken
    set_slot(1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 1'b1);
    step();

    set_slot(0, 1'b1, 4'd1, 3'd1, 16'h0000, 1'b0, 1'b1);   // add R1=0 -> z
    set_slot(1, 1'b1, 4'd0, 3'b010, 16'h3000, 1'b0, 1'b1); // brz predicted not taken
    step();
    step();                                            // flush cycle retires nothing
    clear_slots();
    step();

    set_slot(0, 1'b1, 4'd1, 3'd3, 16'h0011, 1'b0, 1'b1);   // both write R3
    set_slot(1, 1'b1, 4'd5, 3'd3, 16'h0022, 1'b0, 1'b0);
    step();

    clear_slots();
    set_slot(0, 1'b1, 4'd7, 3'd0, 16'h4000, 1'b0, 1'b1);   // str
    dmem_resp = 1'b1; step();                          // resp ignored while IDLE
    dmem_resp = 1'b0; step(); step();
    dmem_resp = 1'b1; step();
    dmem_resp = 1'b0; clear_slots(); step();

    set_slot(0, 1'b1, 4'd1, 3'd4, 16'h0007, 1'b0, 1'b1);   // add then stb
    set_slot(1, 1'b1, 4'd3, 3'd0, 16'h5000, 1'b0, 1'b1);
    step();
    clear_slots();
    set_slot(0, 1'b1, 4'd3, 3'd0, 16'h5000, 1'b0, 1'b1);
    step();                                            // enters WAIT
    step();
    #1 rst = 1'b1;                                     // abort mid-WAIT
    step();
    rst = 1'b0;
    clear_slots();
    set_slot(0, 1'b1, 4'd0, 3'b010, 16'h2000, 1'b1, 1'b1); // CC back to z
    step();
    set_slot(0, 1'b1, 4'd0, 3'b010, 16'h2100, 1'b0, 1'b1);
    step();
    clear_slots();
    step();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++) begin
        logic [15:0] val;
        case ($urandom_range(0, 3))
          0:       val = 16'h0000;
          1:       val = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
          default: val = 16'($urandom_range(0, 16'hFFFF));
        endcase
        set_slot(i, $urandom_range(0, 9) < 8, ops[$urandom_range(0, 11)],
                 3'($urandom_range(0, 7)), val, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
      dmem_resp = $urandom_range(0, 9) < 4;
      rst = (c == 200);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/commit_unit_multi.md
Name: commit_unit_multi

Overview:
Parametrised in-order retirement stage for the out-of-order LC-3b core. It sits between the ROB head window and the regfile, fetch unit, data memory and ld/str buffer. It retires up to COMMIT_WIDTH head entries per cycle, resolves branches against a CC chain, drives stores through a memory handshake FSM, and issues a registered flush with redirect PC on mispredict. It also keeps retire and mispredict performance counters.

Parameters:
COMMIT_WIDTH, 2, head entries examined and retired per cycle (1..4).
DATA_WIDTH, 16, value width.
TAG_WIDTH, 3, ROB address width.
CNT_WIDTH, 32, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
head_valid  in  W  slot i holds a completed ROB entry; slot 0 is the oldest
head_opcode  in  W*4  lc3b_opcode per slot
head_dest  in  W*3  dest reg, or nzp field for br
head_value  in  W*DATA_WIDTH  result, or target PC for br
head_predict  in  W  predicted taken, per slot
head_rob_addr  in  W*TAG_WIDTH  ROB index per slot
rat_tag  in  W*TAG_WIDTH  current rename tag of head_dest[i]
dmem_resp  in  1  data memory done
rf_dest  out  W*3  regfile write address per port
rf_value  out  W*DATA_WIDTH  regfile write data per port
rf_ld_value  out  W  regfile value write enable per port
rf_ld_busy  out  W  clear busy bit per port
retire_count  out  $clog2(W+1)  entries the ROB pops this cycle
flush  out  1  pipeline flush
pcmux_sel  out  1  fetch redirect
new_pc  out  16  redirect target
dmem_write  out  1  store request
ldstr_re  out  1  pop the ld/str buffer
perf_retired  out  CNT_WIDTH  total retired entries
perf_mispredict  out  CNT_WIDTH  total mispredicts

Behaviour:
- Reset (asynchronous):
  - all outputs 0.
  - CC register 3'b010.
  - Store FSM in IDLE.
  - Flush register 0.
  - Counters 0.
- Retirement is a prefix. Slot i retires only if slots 0..i-1 retire this cycle and head_valid[i]=1. retire_count equals the prefix length.
- Slot classes:
  - ALU class: add, and, not, shf, lea, ldr.
  - jsr.
  - br.
  - Store class: str, stb.
  - Any other opcode retires with no side effect.
- CC chain:
  - cc_0 is the CC register.
  - cc_{i+1} = gencc(head_value[i]) if slot i is ALU class and retires; otherwise cc_{i+1} = cc_i.
  - At the end of the cycle the CC register loads the last cc_i.
  - jsr does not update CC.
- Branch at slot i: taken = |(cc_i & nzp).
  - If taken == predict, the branch retires and the prefix continues.
  - If taken != predict (mispredict), the branch retires, slots above i do not retire, and on the next edge flush_q <= 1 and pc_q <= head_value[i].
  - flush, pcmux_sel and new_pc are driven from the registers and are high for exactly one cycle.
  - During the flush cycle retire_count=0 and the FSM is forced to IDLE.
- Regfile writes:
  - ALU class and jsr set rf_ld_value[i] for retiring slot i.
  - If a younger slot retiring in the same cycle writes the same dest, rf_ld_value[i] is suppressed.
  - rf_ld_busy[i] = rf_ld_value[i] && (rat_tag[i] == head_rob_addr[i]).
- Stores:
  - A store only retires from slot 0. A store at slot k>0 ends the prefix at k.
  - Store FSM, IDLE: if slot 0 is a valid store and there is no flush, go to WAIT with dmem_write=1 in the same cycle. retire_count=0.
  - Store FSM, WAIT: dmem_write=1. When dmem_resp=1, retire_count=1, ldstr_re=1, return to IDLE.
  - dmem_resp is ignored in IDLE.
  - If rst is asserted while in WAIT, the FSM aborts; the store has not retired.
- Counters:
  - perf_retired += retire_count every cycle.
  - perf_mispredict += 1 per mispredict.
  - Both wrap modulo 2^CNT_WIDTH.
- Latency:
  - Regfile and ROB side effects are combinational in the retiring cycle.
  - Redirect and flush appear 1 cycle after the mispredict retires.

Decomposition:
- Package lc3b_types gains typedef commit_state_t {IDLE, WAIT} and function is_alu_class(lc3b_opcode).
- Reuse the existing gencc and cccomp.
- One sub-module, commit_slot_decode: per-slot class, CC-in/CC-out, and taken/mispredict. Instantiate it W times in a generate loop.

Test Plan:
- W=2, slot0 add R1=0x0005, slot1 add R2=0xFFFE, rat tags match -> retire_count=2, both rf_ld_value and both rf_ld_busy = 1, CC=3'b100.
- Slot0 add R1=0 (z), slot1 brz predict=0, target 0x3000 -> retire_count=2; next cycle flush=pcmux_sel=1, new_pc=0x3000, retire_count=0; perf_mispredict=1.
- Slot0 and slot1 both write R3, values 0x11 and 0x22 -> only port 1 writes (0x22); rf_ld_value=2'b10.
- Slot0 str, dmem_resp delayed 3 cycles -> dmem_write high 4 cycles, retire_count=0 until the resp cycle, then retire_count=1 and ldstr_re=1 for exactly one cycle.
- Slot0 add, slot1 stb -> cycle 1 retire_count=1; the store then enters WAIT from slot 0.
- Assert rst mid-WAIT -> dmem_write=0 immediately, FSM IDLE, counters 0, CC=3'b010.
